// File: rtl/code_loader.sv
// ---------------------------------------------------------------------------
// code_loader
//
// Byte-stream program loader that drives the processor's code-memory load
// port. Bytes arrive over a valid/ready handshake and are checked and written
// to code memory. When the whole program has arrived and its checksum matches,
// the loader releases the control unit by raising run.
//
// Stream layout:
//   length (16-bit word count, high byte first)
//   N words (high byte first)
//   one checksum byte (XOR of all 2N code bytes; length bytes are excluded)
//
// Parameters:
//   ADDR_W  - code-memory address width; programs hold up to 2**ADDR_W words
//   TIMEOUT - idle cycles allowed between accepted bytes while loading;
//             0 disables the timeout
//
// Ports:
//   i_clk          - system clock, rising-edge active
//   i_rst          - asynchronous active-high reset
//   i_start        - one-cycle pulse; starts a load from IDLE/DONE/ERROR
//   i_rx_data      - incoming byte
//   i_rx_valid     - i_rx_data holds a byte
//   o_rx_ready     - loader takes a byte this cycle if i_rx_valid is high
//   o_code_w_en    - one-cycle code-memory write pulse per word
//   o_code_addr_in - code-memory write address
//   o_code_in      - code-memory write data
//   o_run          - processor run enable (after a good load)
//   o_busy         - load in progress
//   o_done         - last load succeeded (level)
//   o_err          - last load failed (level)
//   o_err_code     - 00 none, 01 bad length, 10 checksum, 11 timeout
// ---------------------------------------------------------------------------
module code_loader #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 1000000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  output logic              o_code_w_en,
  output logic [ADDR_W-1:0] o_code_addr_in,
  output logic [15:0]       o_code_in,
  output logic              o_run,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [1:0]        o_err_code
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    CHK,
    DONE,
    ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CHK  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  // Largest legal word count, held in 17 bits so 2**16 still fits.
  localparam logic [16:0] MAX_WORDS = 17'(1 << ADDR_W);
  localparam bit          TMO_EN    = (TIMEOUT > 0);
  localparam logic [31:0] TMO_LAST  = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  state_t              r_state;
  state_t              w_next_state;
  logic [15:0]         r_len;
  logic [7:0]          r_hi;
  logic [7:0]          r_chk;
  logic [15:0]         r_code_in;
  logic                r_w_en;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_run;
  logic                r_done;
  logic                r_err;
  logic [1:0]          r_err_code;
  logic [31:0]         r_tmo;

  logic                w_accept;
  logic                w_busy;
  logic                w_ready;
  logic [15:0]         w_len_full;
  logic                w_len_bad;
  logic                w_last_word;
  logic                w_tmo_hit;
  logic                w_start_load;
  logic                w_go_done;
  logic                w_go_err;
  logic [1:0]          w_err_kind;

  // Handshake and status decode depend on the registered state only, so the
  // ready signal never combinationally follows rx_valid or start.
  assign w_ready  = r_state inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK};
  assign w_busy   = !(r_state inside {IDLE, DONE, ERROR});
  assign w_accept = i_rx_valid & w_ready;

  // Full length as it will look once the low byte lands; the comparison is
  // done in 17 bits so the 2**ADDR_W limit is exact for any ADDR_W up to 16.
  assign w_len_full = {r_len[15:8], i_rx_data};
  assign w_len_bad  = (w_len_full == 16'd0) || ({1'b0, w_len_full} > MAX_WORDS);

  // The address counter doubles as the word index: the previous word's pulse
  // has always bumped it before the next low byte can be accepted.
  assign w_last_word = (({{(17 - ADDR_W){1'b0}}, r_addr} + 17'd1) == {1'b0, r_len});

  assign w_tmo_hit = TMO_EN && (r_tmo == TMO_LAST);

  // Next-state logic. Load errors and success are flagged here so the status
  // register block only has to latch them. The timeout override sits last and
  // is blocked by an accept, so a byte arriving on the final allowed cycle
  // still counts.
  always_comb begin
    w_next_state = r_state;
    w_start_load = 1'b0;
    w_go_done    = 1'b0;
    w_go_err     = 1'b0;
    w_err_kind   = ERR_NONE;
    case (r_state)
      IDLE, DONE, ERROR: begin
        if (i_start) begin
          w_start_load = 1'b1;
          w_next_state = LEN_HI;
        end
      end
      LEN_HI: begin
        if (w_accept) w_next_state = LEN_LO;
      end
      LEN_LO: begin
        if (w_accept) begin
          if (w_len_bad) begin
            w_next_state = ERROR;
            w_go_err     = 1'b1;
            w_err_kind   = ERR_LEN;
          end else begin
            w_next_state = DATA_HI;
          end
        end
      end
      DATA_HI: begin
        if (w_accept) w_next_state = DATA_LO;
      end
      DATA_LO: begin
        if (w_accept) w_next_state = w_last_word ? CHK : DATA_HI;
      end
      CHK: begin
        if (w_accept) begin
          if (i_rx_data == r_chk) begin
            w_next_state = DONE;
            w_go_done    = 1'b1;
          end else begin
            w_next_state = ERROR;
            w_go_err     = 1'b1;
            w_err_kind   = ERR_CHK;
          end
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
    if (w_busy && !w_accept && w_tmo_hit) begin
      w_next_state = ERROR;
      w_go_done    = 1'b0;
      w_go_err     = 1'b1;
      w_err_kind   = ERR_TMO;
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Byte datapath: length capture, high-byte holding register, running
  // checksum and the write data/strobe. The high byte is parked in r_hi, not
  // in r_code_in, so a byte taken during a write pulse cannot disturb the
  // data currently presented to code memory.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_len     <= '0;
      r_hi      <= '0;
      r_chk     <= '0;
      r_code_in <= '0;
      r_w_en    <= 1'b0;
    end else begin
      r_w_en <= 1'b0;
      if (w_start_load) begin
        r_chk <= '0;
      end
      case (r_state)
        LEN_HI: begin
          if (w_accept) r_len[15:8] <= i_rx_data;
        end
        LEN_LO: begin
          if (w_accept) r_len[7:0] <= i_rx_data;
        end
        DATA_HI: begin
          if (w_accept) begin
            r_hi  <= i_rx_data;
            r_chk <= r_chk ^ i_rx_data;
          end
        end
        DATA_LO: begin
          if (w_accept) begin
            r_code_in <= {r_hi, i_rx_data};
            r_chk     <= r_chk ^ i_rx_data;
            r_w_en    <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Write address. It moves on the edge that ends each write pulse, so the
  // address stays steady for the whole pulse. After the top word it wraps
  // to 0 naturally; by then the FSM is in CHK, so no further write follows.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr <= '0;
    end else if (w_start_load) begin
      r_addr <= '0;
    end else if (r_w_en) begin
      r_addr <= r_addr + 1'b1;
    end
  end

  // Result flags. These are levels that hold until the next start.
  // run is only ever set on entry to DONE, so it is low whenever busy.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_run      <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else if (w_start_load) begin
      r_run      <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else if (w_go_done) begin
      r_run  <= 1'b1;
      r_done <= 1'b1;
    end else if (w_go_err) begin
      r_err      <= 1'b1;
      r_err_code <= w_err_kind;
    end
  end

  // Inter-byte idle counter. It restarts on every accepted byte and on start,
  // and only runs while a load is in progress.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tmo <= '0;
    end else if (w_start_load || w_accept) begin
      r_tmo <= '0;
    end else if (w_busy && TMO_EN) begin
      r_tmo <= r_tmo + 32'd1;
    end
  end

  assign o_rx_ready     = w_ready;
  assign o_busy         = w_busy;
  assign o_code_w_en    = r_w_en;
  assign o_code_addr_in = r_addr;
  assign o_code_in      = r_code_in;
  assign o_run          = r_run;
  assign o_done         = r_done;
  assign o_err          = r_err;
  assign o_err_code     = r_err_code;

endmodule

// File: tb/tb_code_loader.sv
// ---------------------------------------------------------------------------
// tb_code_loader
//
// Directed testbench for code_loader with ADDR_W=9 and TIMEOUT=16. Each
// scenario task drives its own byte stream and compares outputs against
// hand-computed values. A negedge monitor logs every write pulse as an
// address/data pair.
// ---------------------------------------------------------------------------
module tb_code_loader;

  localparam int ADDR_W  = 9;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        rxData;
  logic              rxValid;
  logic              rxReady;
  logic              codeWEn;
  logic [ADDR_W-1:0] codeAddrIn;
  logic [15:0]       codeIn;
  logic              run;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        errCode;

  int errors = 0;
  int checks = 0;

  logic [ADDR_W-1:0] wrAddr[$];
  logic [15:0]       wrData[$];
  logic [7:0]        streamQ[$];
  int                gapQ[$];

  code_loader #(
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_rx_data     (rxData),
    .i_rx_valid    (rxValid),
    .o_rx_ready    (rxReady),
    .o_code_w_en   (codeWEn),
    .o_code_addr_in(codeAddrIn),
    .o_code_in     (codeIn),
    .o_run         (run),
    .o_busy        (busy),
    .o_done        (done),
    .o_err         (err),
    .o_err_code    (errCode)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Log each cycle that the write strobe is high, sampled mid-cycle.
  // A strobe that stays high too long appears as extra entries.
  always @(negedge clk) begin
    if (codeWEn === 1'b1) begin
      wrAddr.push_back(codeAddrIn);
      wrData.push_back(codeIn);
    end
  end

  task automatic clearWrites();
    wrAddr.delete();
    wrData.delete();
  endtask

  // Offer one byte after gap idle cycles, then hold it until the DUT takes
  // it. Returns 1 ns after the accepting edge. With gap 0, rx_valid stays
  // high straight through from the previous byte.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int waitCycles;
    if (gap > 0) begin
      rxValid = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    rxData     = b;
    rxValid    = 1'b1;
    waitCycles = 0;
    while (1) begin
      @(negedge clk);
      if (rxReady === 1'b1) break;
      waitCycles++;
      if (waitCycles > 40) begin
        errors++;
        checks++;
        $display("[TB] FAIL byte_accept: byte %02h not taken, rx_ready=%b required 1", b, rxReady);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sendStream();
    for (int i = 0; i < streamQ.size(); i++) begin
      applyStimulus(streamQ[i], (i < gapQ.size()) ? gapQ[i] : 0);
    end
    rxValid = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Three-word program; checksum byte is 12^34^AB^CD^00^01 = 41.
  task automatic loadBasic(input logic [7:0] chkByte);
    streamQ = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};
    streamQ.push_back(chkByte);
  endtask

  // Outputs must all be low while reset is held, with no clock edge needed.
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rxValid = 1'b0; rxData = 8'h00;
    #3;
    checks++; if (rxReady !== 1'b0) begin errors++; $display("[TB] FAIL reset_rx_ready: got %b want 0", rxReady); end
    checks++; if (codeWEn !== 1'b0) begin errors++; $display("[TB] FAIL reset_w_en: got %b want 0", codeWEn); end
    checks++; if (codeAddrIn !== '0) begin errors++; $display("[TB] FAIL reset_addr: got %0d want 0", codeAddrIn); end
    checks++; if (codeIn !== 16'h0000) begin errors++; $display("[TB] FAIL reset_code_in: got %04h want 0000", codeIn); end
    checks++; if ({run, busy, done, err} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags: run/busy/done/err got %b want 0000", {run, busy, done, err}); end
    checks++; if (errCode !== 2'b00) begin errors++; $display("[TB] FAIL reset_err_code: got %b want 00", errCode); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_load();
    logic [15:0] expData[3];
    expData = '{16'h1234, 16'hABCD, 16'h0001};
    clearWrites();
    pulseStart();
    checks++; if ({busy, rxReady} !== 2'b11) begin errors++; $display("[TB] FAIL basic_started: busy/ready got %b want 11", {busy, rxReady}); end
    loadBasic(8'h41);
    gapQ.delete();
    sendStream();
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (wrAddr.size() != 3) begin errors++; $display("[TB] FAIL basic_write_count: got %0d want 3", wrAddr.size()); end
    if (wrAddr.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (wrAddr[i] !== ADDR_W'(i)) begin errors++; $display("[TB] FAIL basic_addr%0d: got %0d want %0d", i, wrAddr[i], i); end
        checks++; if (wrData[i] !== expData[i]) begin errors++; $display("[TB] FAIL basic_data%0d: got %04h want %04h", i, wrData[i], expData[i]); end
      end
    end
    checks++; if ({done, run, err, busy} !== 4'b1100) begin errors++; $display("[TB] FAIL basic_status: done/run/err/busy got %b want 1100", {done, run, err, busy}); end
    checks++; if (errCode !== 2'b00) begin errors++; $display("[TB] FAIL basic_err_code: got %b want 00", errCode); end
  endtask

  task automatic test_checksum_error();
    clearWrites();
    pulseStart();
    loadBasic(8'h44);
    gapQ.delete();
    sendStream();
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (wrAddr.size() != 3) begin errors++; $display("[TB] FAIL chk_write_count: got %0d want 3", wrAddr.size()); end
    checks++; if ({err, run, done} !== 3'b100) begin errors++; $display("[TB] FAIL chk_status: err/run/done got %b want 100", {err, run, done}); end
    checks++; if (errCode !== 2'b10) begin errors++; $display("[TB] FAIL chk_err_code: got %b want 10", errCode); end
  endtask

  task automatic test_bad_length();
    clearWrites();
    pulseStart();
    streamQ = '{8'h00, 8'h00};
    gapQ.delete();
    sendStream();
    repeat (3) begin @(posedge clk); #1; end
    checks++; if ({err, errCode, busy, rxReady} !== 5'b10100) begin errors++; $display("[TB] FAIL len0_status: err/code/busy/ready got %b want 10100", {err, errCode, busy, rxReady}); end
    // 0x0201 = 513 words, one past the 512-word memory.
    pulseStart();
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL len_restart_err_clear: got %b want 0", err); end
    streamQ = '{8'h02, 8'h01};
    sendStream();
    repeat (3) begin @(posedge clk); #1; end
    checks++; if ({err, errCode} !== 3'b101) begin errors++; $display("[TB] FAIL len513_status: err/code got %b want 101", {err, errCode}); end
    checks++; if (wrAddr.size() != 0) begin errors++; $display("[TB] FAIL len_no_write: got %0d writes want 0", wrAddr.size()); end
  endtask

  // Full 512-word program: every address is used, and the counter wraps to 0.
  task automatic test_max_length();
    logic [7:0]  chk;
    logic [15:0] w;
    int          bad;
    clearWrites();
    pulseStart();
    streamQ = '{8'h02, 8'h00};
    chk = 8'h00;
    for (int i = 0; i < 512; i++) begin
      w = {8'(i), 8'(i >> 1) ^ 8'hA5};
      streamQ.push_back(w[15:8]);
      streamQ.push_back(w[7:0]);
      chk = chk ^ w[15:8] ^ w[7:0];
    end
    streamQ.push_back(chk);
    gapQ.delete();
    sendStream();
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (wrAddr.size() != 512) begin errors++; $display("[TB] FAIL max_write_count: got %0d want 512", wrAddr.size()); end
    bad = 0;
    for (int i = 0; i < wrAddr.size() && i < 512; i++) begin
      w = {8'(i), 8'(i >> 1) ^ 8'hA5};
      if (wrAddr[i] !== ADDR_W'(i) || wrData[i] !== w) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL max_words: got %0d wrong words want 0", bad); end
    checks++; if ({done, run, err} !== 3'b110) begin errors++; $display("[TB] FAIL max_status: done/run/err got %b want 110", {done, run, err}); end
    checks++; if (codeAddrIn !== '0) begin errors++; $display("[TB] FAIL max_addr_wrap: got %0d want 0", codeAddrIn); end
  endtask

  task automatic test_backpressure();
    logic [15:0] expData[3];
    expData = '{16'h1234, 16'hABCD, 16'h0001};
    clearWrites();
    pulseStart();
    loadBasic(8'h41);
    gapQ = '{3, 0, 5, 1, 2, 0, 4, 1, 5};
    sendStream();
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (wrAddr.size() != 3) begin errors++; $display("[TB] FAIL bp_write_count: got %0d want 3", wrAddr.size()); end
    if (wrAddr.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (wrAddr[i] !== ADDR_W'(i) || wrData[i] !== expData[i]) begin errors++; $display("[TB] FAIL bp_word%0d: got %0d/%04h want %0d/%04h", i, wrAddr[i], wrData[i], i, expData[i]); end
      end
    end
    checks++; if ({done, run, err} !== 3'b110) begin errors++; $display("[TB] FAIL bp_status: done/run/err got %b want 110", {done, run, err}); end
  endtask

  // Cycle-level pulse timing with rx_valid held high through each pulse.
  task automatic test_back_to_back();
    clearWrites();
    pulseStart();
    applyStimulus(8'h00, 0);
    applyStimulus(8'h03, 0);
    applyStimulus(8'h12, 0);
    applyStimulus(8'h34, 0);
    checks++; if ({codeWEn, codeAddrIn, codeIn} !== {1'b1, 9'd0, 16'h1234}) begin errors++; $display("[TB] FAIL b2b_pulse0: w_en/addr/data got %b/%0d/%04h want 1/0/1234", codeWEn, codeAddrIn, codeIn); end
    applyStimulus(8'hAB, 0);
    checks++; if ({codeWEn, codeAddrIn, codeIn} !== {1'b0, 9'd1, 16'h1234}) begin errors++; $display("[TB] FAIL b2b_after_hi: w_en/addr/data got %b/%0d/%04h want 0/1/1234", codeWEn, codeAddrIn, codeIn); end
    applyStimulus(8'hCD, 0);
    checks++; if ({codeWEn, codeAddrIn, codeIn} !== {1'b1, 9'd1, 16'hABCD}) begin errors++; $display("[TB] FAIL b2b_pulse1: w_en/addr/data got %b/%0d/%04h want 1/1/ABCD", codeWEn, codeAddrIn, codeIn); end
    applyStimulus(8'h00, 0);
    applyStimulus(8'h01, 0);
    checks++; if ({codeWEn, codeAddrIn, codeIn} !== {1'b1, 9'd2, 16'h0001}) begin errors++; $display("[TB] FAIL b2b_pulse2: w_en/addr/data got %b/%0d/%04h want 1/2/0001", codeWEn, codeAddrIn, codeIn); end
    applyStimulus(8'h41, 0);
    rxValid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (wrAddr.size() != 3) begin errors++; $display("[TB] FAIL b2b_write_count: got %0d want 3", wrAddr.size()); end
    checks++; if ({done, run, codeAddrIn} !== {2'b11, 9'd3}) begin errors++; $display("[TB] FAIL b2b_end: done/run/addr got %b/%b/%0d want 1/1/3", done, run, codeAddrIn); end
  endtask

  task automatic test_timeout();
    clearWrites();
    pulseStart();
    applyStimulus(8'h00, 0);
    applyStimulus(8'h02, 0);
    applyStimulus(8'h12, 0);
    rxValid = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    checks++; if ({busy, err} !== 2'b10) begin errors++; $display("[TB] FAIL tmo_early: busy/err got %b want 10 after 15 idle cycles", {busy, err}); end
    @(posedge clk);
    #1;
    checks++; if ({err, errCode, busy} !== 4'b1110) begin errors++; $display("[TB] FAIL tmo_fire: err/code/busy got %b want 1110 after 16 idle cycles", {err, errCode, busy}); end
    checks++; if (wrAddr.size() != 0) begin errors++; $display("[TB] FAIL tmo_no_write: got %0d writes want 0", wrAddr.size()); end
    clearWrites();
    pulseStart();
    loadBasic(8'h41);
    gapQ.delete();
    sendStream();
    repeat (2) begin @(posedge clk); #1; end
    checks++; if ({done, run, err, errCode} !== 5'b11000 || wrAddr.size() != 3) begin errors++; $display("[TB] FAIL tmo_reload: done/run/err/code got %b, writes %0d want 11000, 3", {done, run, err, errCode}, wrAddr.size()); end
  endtask

  task automatic test_reset_mid();
    clearWrites();
    pulseStart();
    applyStimulus(8'h00, 0);
    applyStimulus(8'h03, 0);
    applyStimulus(8'h12, 0);
    applyStimulus(8'h34, 0);
    applyStimulus(8'hAB, 0);
    rxValid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({busy, rxReady, codeWEn, run, done, err} !== 6'b000000) begin errors++; $display("[TB] FAIL rstmid_flags: busy/ready/w_en/run/done/err got %b want 000000", {busy, rxReady, codeWEn, run, done, err}); end
    checks++; if ({codeAddrIn, codeIn, errCode} !== '0) begin errors++; $display("[TB] FAIL rstmid_data: addr/data/code got %0d/%04h/%b want 0/0000/00", codeAddrIn, codeIn, errCode); end
    checks++; if (wrAddr.size() != 1) begin errors++; $display("[TB] FAIL rstmid_writes: got %0d want 1", wrAddr.size()); end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++; if ({busy, rxReady} !== 2'b00) begin errors++; $display("[TB] FAIL rstmid_idle: busy/ready got %b want 00", {busy, rxReady}); end
  endtask

  task automatic test_start_busy();
    clearWrites();
    pulseStart();
    applyStimulus(8'h00, 0);
    applyStimulus(8'h03, 0);
    applyStimulus(8'h12, 0);
    rxValid = 1'b0;
    pulseStart();
    checks++; if ({busy, rxReady} !== 2'b11) begin errors++; $display("[TB] FAIL busy_start_state: busy/ready got %b want 11", {busy, rxReady}); end
    streamQ = '{8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'h41};
    gapQ.delete();
    sendStream();
    repeat (2) begin @(posedge clk); #1; end
    checks++; if ({done, run, err} !== 3'b110 || wrAddr.size() != 3) begin errors++; $display("[TB] FAIL busy_start_ignored: done/run/err got %b, writes %0d want 110, 3", {done, run, err}, wrAddr.size()); end
  endtask

  task automatic test_start_done();
    checks++; if (run !== 1'b1) begin errors++; $display("[TB] FAIL done_run_before: got %b want 1", run); end
    pulseStart();
    checks++; if ({run, done, busy} !== 3'b001) begin errors++; $display("[TB] FAIL done_restart: run/done/busy got %b want 001", {run, done, busy}); end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_checksum_error();
    test_bad_length();
    test_max_length();
    test_backpressure();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_start_busy();
    test_start_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
